replace_order_encoder: RTL and testbench

Serializer for ITCH 5.0 Replace Order ('U') messages, the transmit-side counterpart of the replace order decoder. It accepts one parsed message per handshake (old ref, new ref, shares, price) and emits the 27-byte wire image one byte per cycle. The byte stream uses a valid/ready interface. Intended uses are the loopback test harness and the outbound order-update path feeding the ITCH byte stream.

---
 rtl/replace_order_encoder.sv | 109 ++++++++++
 tb/tb_replace_order_encoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/replace_order_encoder.sv
// replace_order_encoder: serializes ITCH 5.0 Replace Order ('U') messages into a big-endian byte stream
module replace_order_encoder #(
  parameter logic [7:0] MSG_TYPE   = 8'h55,
  parameter int         MSG_LENGTH = 27,
  parameter int         GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [63:0] msg_old_order_ref,
  input  logic [63:0] msg_new_order_ref,
  input  logic [31:0] msg_shares,
  input  logic [31:0] msg_price,
  output logic [7:0]  byte_out,
  output logic        valid_out,
  input  logic        ready_out,
  output logic        last_out,
  output logic        busy,
  output logic [15:0] msg_sent_count
);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  localparam logic [5:0] LAST     = 6'(MSG_LENGTH - 1);
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);
  state_t state_q, state_d;
  logic [215:0] act_q, act_d;
  logic [191:0] pend_q, pend_d, in_msg;
  logic pend_full_q, pend_full_d;
  logic [5:0] idx_q, idx_d;
  logic [3:0] gap_q, gap_d;
  logic valid_q, valid_d, last_q, last_d, ready_q, ready_d, busy_q, busy_d;
  logic [15:0] cnt_q, cnt_d;
  logic accept, fire, done, free;
  always_comb begin
    in_msg      = {msg_old_order_ref, msg_new_order_ref, msg_shares, msg_price};
    accept      = msg_valid && ready_q;
    fire        = valid_q && ready_out;
    done        = state_q == SEND && fire && idx_q == LAST;
    free        = state_q == IDLE || (done && GAP_CYCLES == 0) || (state_q == GAP && gap_q == 4'd0);
    state_d     = state_q;
    act_d       = act_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    valid_d     = valid_q;
    last_d      = last_q;
    cnt_d       = done ? cnt_q + 16'd1 : cnt_q;
    if (free) begin
      state_d     = (pend_full_q || accept) ? SEND : IDLE;
      act_d       = (pend_full_q || accept) ? {MSG_TYPE, pend_full_q ? pend_q : in_msg, 16'h0} : '0;
      valid_d     = pend_full_q || accept;
      idx_d       = 6'd0;
      last_d      = 1'b0;
      pend_full_d = 1'b0;
    end else if (done) begin
      state_d = GAP;
      gap_d   = GAP_LOAD;
      act_d   = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (state_q == GAP) begin
      gap_d = gap_q - 4'd1;
    end else if (fire) begin
      act_d  = act_q << 8;
      idx_d  = idx_q + 6'd1;
      last_d = idx_q + 6'd1 == LAST;
    end
    if (accept && !(free && !pend_full_q)) begin
      pend_d      = in_msg;
      pend_full_d = 1'b1;
    end
    ready_d = !pend_full_d;
    busy_d  = state_d != IDLE || pend_full_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      act_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      idx_q       <= 6'd0;
      gap_q       <= 4'd0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      cnt_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end
  assign msg_ready      = ready_q;
  assign byte_out       = act_q[215:208];
  assign valid_out      = valid_q;
  assign last_out       = last_q;
  assign busy           = busy_q;
  assign msg_sent_count = cnt_q;
endmodule

// File: tb/tb_replace_order_encoder.sv
// tb_replace_order_encoder: randomized byte-queue reference checks of the replace order encoder
module tb_replace_order_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic msg_valid = 1'b0, g_msg_valid = 1'b0, ready_out = 1'b1;
  logic [63:0] old_ref = '0, new_ref = '0;
  logic [31:0] shares = '0, price = '0;
  logic msg_ready, valid_out, last_out, busy;
  logic [7:0] byte_out;
  logic [15:0] msg_sent_count;
  logic g_msg_ready, g_valid_out, g_last_out, g_busy;
  logic [7:0] g_byte_out;
  logic [15:0] g_msg_sent_count;
  replace_order_encoder u_dut (
    .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_old_order_ref(old_ref), .msg_new_order_ref(new_ref), .msg_shares(shares), .msg_price(price),
    .byte_out(byte_out), .valid_out(valid_out), .ready_out(ready_out), .last_out(last_out),
    .busy(busy), .msg_sent_count(msg_sent_count)
  );
  replace_order_encoder #(.GAP_CYCLES(3)) u_gap (
    .clk(clk), .rst(rst), .msg_valid(g_msg_valid), .msg_ready(g_msg_ready),
    .msg_old_order_ref(old_ref), .msg_new_order_ref(new_ref), .msg_shares(shares), .msg_price(price),
    .byte_out(g_byte_out), .valid_out(g_valid_out), .ready_out(ready_out), .last_out(g_last_out),
    .busy(g_busy), .msg_sent_count(g_msg_sent_count)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  int pos = 0, exp_cnt = 0, cyc = 0, first_fire = -1, last_fire = 0;
  logic hold_prev = 1'b0;
  logic [7:0] prev_byte = '0;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic rand_fields();
    old_ref = {$urandom, $urandom};
    new_ref = {$urandom, $urandom};
    shares  = $urandom;
    price   = $urandom;
  endtask
  task automatic push_msg();
    exp_q.push_back(8'h55);
    for (int i = 7; i >= 0; i--) exp_q.push_back(old_ref[i*8 +: 8]);
    for (int i = 7; i >= 0; i--) exp_q.push_back(new_ref[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(shares[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(price[i*8 +: 8]);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
  endtask
  task automatic cycle();
    if (!rst) begin
      if (!valid_out) chk("idle_zero", 64'(byte_out), 64'd0);
      if (hold_prev) begin
        chk("hold_valid", 64'(valid_out), 64'd1);
        chk("hold_byte", 64'(byte_out), 64'(prev_byte));
      end
      chk("sent_count", 64'(msg_sent_count), 64'(exp_cnt & 16'hFFFF));
      if (valid_out && ready_out) begin
        if (exp_q.size() == 0) chk("extra_byte", 64'(valid_out), 64'd0);
        else begin
          chk($sformatf("byte%0d", pos), 64'(byte_out), 64'(exp_q.pop_front()));
          chk($sformatf("last%0d", pos), 64'(last_out), 64'(pos == 26));
          if (first_fire < 0) first_fire = cyc;
          last_fire = cyc;
          pos++;
          if (pos == 27) begin
            pos = 0;
            exp_cnt++;
          end
        end
      end
      hold_prev = valid_out && !ready_out;
      prev_byte = byte_out;
      if (msg_valid && msg_ready) push_msg();
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      cycle();
      g++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask
  initial begin
    int n, g, stall, idle, acc;
    logic a, saw_block, seen_last, gdone;
    @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(valid_out), 64'd0);
    chk("rst_last", 64'(last_out), 64'd0);
    chk("rst_byte", 64'(byte_out), 64'd0);
    chk("rst_ready", 64'(msg_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(msg_sent_count), 64'd0);
    rst = 1'b0;
    old_ref = 64'h0102030405060708;
    new_ref = 64'h1112131415161718;
    shares  = 32'h000003E8;
    price   = 32'h00989680;
    msg_valid = 1'b1;
    cycle();
    msg_valid = 1'b0;
    chk("lat_valid", 64'(valid_out), 64'd1);
    chk("lat_byte", 64'(byte_out), 64'h55);
    chk("lat_busy", 64'(busy), 64'd1);
    drain();
    chk("t1_count", 64'(msg_sent_count), 64'd1);
    chk("t1_valid", 64'(valid_out), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    first_fire = -1;
    saw_block = 1'b0;
    n = 0;
    g = 0;
    rand_fields();
    msg_valid = 1'b1;
    while (n < 3 && g < 500) begin
      a = msg_ready;
      if (!msg_ready) saw_block = 1'b1;
      cycle();
      g++;
      if (a) begin
        n++;
        rand_fields();
        if (n == 3) msg_valid = 1'b0;
      end
    end
    msg_valid = 1'b0;
    drain();
    chk("b2b_span", 64'(last_fire - first_fire), 64'd80);
    chk("b2b_block", 64'(saw_block), 64'd1);
    chk("b2b_count", 64'(msg_sent_count), 64'd4);
    rand_fields();
    msg_valid = 1'b1;
    cycle();
    msg_valid = 1'b0;
    stall = 0;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      if (valid_out && pos == 12 && stall < 5) begin
        ready_out = 1'b0;
        stall++;
        chk("bp_byte", 64'(byte_out), 64'(new_ref[39:32]));
      end else ready_out = 1'b1;
      cycle();
      g++;
    end
    ready_out = 1'b1;
    chk("bp_stalls", 64'(stall), 64'd5);
    chk("bp_count", 64'(msg_sent_count), 64'd5);
    rand_fields();
    msg_valid = 1'b1;
    cycle();
    msg_valid = 1'b0;
    g = 0;
    while (!(valid_out && pos == 10) && g < 100) begin
      cycle();
      g++;
    end
    chk("rst_mid_reached", 64'(pos), 64'd10);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    exp_q.delete();
    pos = 0;
    exp_cnt = 0;
    hold_prev = 1'b0;
    chk("mid_rst_valid", 64'(valid_out), 64'd0);
    chk("mid_rst_count", 64'(msg_sent_count), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(msg_ready), 64'd1);
    rand_fields();
    msg_valid = 1'b1;
    cycle();
    msg_valid = 1'b0;
    chk("restart_valid", 64'(valid_out), 64'd1);
    chk("restart_byte", 64'(byte_out), 64'h55);
    drain();
    acc = 0;
    g = 0;
    rand_fields();
    while ((acc < 100 || exp_q.size() != 0) && g < 20000) begin
      if (!msg_valid && acc < 100) msg_valid = $urandom_range(0, 2) != 0;
      ready_out = $urandom_range(0, 3) != 0;
      a = msg_valid && msg_ready;
      cycle();
      g++;
      if (a) begin
        acc++;
        rand_fields();
        msg_valid = acc < 100 && $urandom_range(0, 2) != 0;
      end
    end
    msg_valid = 1'b0;
    ready_out = 1'b1;
    cycle();
    chk("rand_accepted", 64'(acc), 64'd100);
    chk("rand_drain", 64'(exp_q.size()), 64'd0);
    chk("rand_count", 64'(msg_sent_count), 64'd101);
    seen_last = 1'b0;
    gdone = 1'b0;
    idle = 0;
    n = 0;
    rand_fields();
    g_msg_valid = 1'b1;
    for (int k = 0; k < 200 && !gdone; k++) begin
      if (g_valid_out && g_last_out) begin
        seen_last = 1'b1;
        idle = 0;
      end else if (seen_last && !g_valid_out) begin
        idle++;
        chk("gap_zero", 64'(g_byte_out), 64'd0);
      end else if (seen_last && g_valid_out) begin
        chk("gap_idle", 64'(idle), 64'd3);
        chk("gap_first", 64'(g_byte_out), 64'h55);
        gdone = 1'b1;
      end
      a = g_msg_valid && g_msg_ready;
      cycle();
      if (a) begin
        n++;
        rand_fields();
        if (n == 2) g_msg_valid = 1'b0;
      end
    end
    g_msg_valid = 1'b0;
    chk("gap_seen", 64'(gdone), 64'd1);
    repeat (40) cycle();
    chk("gap_count", 64'(g_msg_sent_count), 64'd2);
    chk("gap_busy", 64'(g_busy), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
